// File: rtl/ternary_neuron_seq.sv
// Purpose : sequences one N-input ternary neuron over a shared 2-synapse multiply/add slice.
// Latency : start at cycle T, beats accepted T+1..T+N/2 (no stalls), done pulse at T+N/2+1.
// Backpr. : w_ready high only in RUN; an idle w_valid stalls the evaluation indefinitely.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         begin an evaluation (only honoured in IDLE)
//   x_in          binary activations, latched on the accepted start
//   w_valid/w_ready  weight pair-beat handshake
//   w_data        {sign1, zero1, sign0, zero0} for inputs x[2k+1], x[2k]
//   busy          high in RUN and DONE
//   done          one-cycle pulse when the result is published
//   acc_out, fire signed sum and threshold decision, held until the next result
module ternary_neuron_seq #(
    parameter int N_INPUTS  = 16,
    parameter int ACC_W     = 6,
    parameter int THRESHOLD = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [N_INPUTS-1:0]     x_in,
    input  logic                    w_valid,
    input  logic [3:0]              w_data,
    output logic                    w_ready,
    output logic                    busy,
    output logic                    done,
    output logic signed [ACC_W-1:0] acc_out,
    output logic                    fire
);

    localparam int NBEATS = N_INPUTS / 2;
    localparam int K_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    localparam logic [K_W-1:0]         K_LAST = K_W'(NBEATS - 1);
    localparam logic signed [ACC_W-1:0] THR   = ACC_W'(THRESHOLD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [N_INPUTS-1:0]     x_q;
    logic [K_W-1:0]          k_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_out_q;
    logic                    fire_q;
    logic                    done_q;
    logic                    busy_q;
    logic                    w_ready_q;

    // Ternary synapse: zero bit dominates the sign bit, an inactive input
    // contributes nothing regardless of the weight.
    function automatic logic signed [1:0] syn_prod(
        input logic x,
        input logic zero,
        input logic sign
    );
        if (!x || zero) begin
            return 2'sd0;
        end else if (sign) begin
            return -2'sd1;
        end else begin
            return 2'sd1;
        end
    endfunction

    // Pair of activations addressed by the current beat index.
    logic [1:0] x_pair;
    always_comb begin
        x_pair = 2'b00;
        for (int b = 0; b < NBEATS; b++) begin
            if (k_q == K_W'(b)) begin
                x_pair = x_q[2*b +: 2];
            end
        end
    end

    logic signed [1:0]       prod0;
    logic signed [1:0]       prod1;
    logic signed [2:0]       pair_sum;
    logic signed [ACC_W-1:0] pair_ext;
    logic signed [ACC_W-1:0] acc_d;
    logic                    beat_acc;
    logic                    last_beat;

    always_comb begin
        prod0     = syn_prod(x_pair[0], w_data[0], w_data[1]);
        prod1     = syn_prod(x_pair[1], w_data[2], w_data[3]);
        // Explicit sign extension of each 2-bit product into the 3-bit pair sum.
        pair_sum  = {prod0[1], prod0} + {prod1[1], prod1};
        pair_ext  = ACC_W'(pair_sum);
        acc_d     = acc_q + pair_ext;
        beat_acc  = w_valid && w_ready_q;
        last_beat = (k_q == K_LAST);
    end

    // Single sequential block: state, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            acc_out_q <= '0;
            fire_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            w_ready_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x_q       <= x_in;
                        acc_q     <= '0;
                        k_q       <= '0;
                        state_q   <= S_RUN;
                        busy_q    <= 1'b1;
                        w_ready_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (beat_acc) begin
                        acc_q <= acc_d;
                        k_q   <= k_q + 1'b1;
                        if (last_beat) begin
                            // Result is published from the sum including this beat.
                            state_q   <= S_DONE;
                            acc_out_q <= acc_d;
                            fire_q    <= (acc_d >= THR);
                            done_q    <= 1'b1;
                            w_ready_q <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    w_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign w_ready = w_ready_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign acc_out = acc_out_q;
    assign fire    = fire_q;

endmodule
